// File: rtl/tmds_pkg.sv
// Shared types, control-period symbols and helpers for the TMDS encoder.
package tmds_pkg;

   typedef logic [9:0]        tmds_sym_t;
   typedef logic signed [4:0] disp_t;

   // Control-period symbols indexed by {C1,C0}.
   localparam tmds_sym_t CTL_00 = 10'b1101010100;
   localparam tmds_sym_t CTL_01 = 10'b0010101011;
   localparam tmds_sym_t CTL_10 = 10'b0101010100;
   localparam tmds_sym_t CTL_11 = 10'b1010101011;

   // Number of set bits in a byte (0..8).
   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, d[i]};
      end
      return n;
   endfunction

   // Control symbol selected by the two control bits {C1,C0}.
   function automatic tmds_sym_t ctl_symbol(input logic [1:0] c);
      tmds_sym_t s;
      case (c)
         2'b00:   s = CTL_00;
         2'b01:   s = CTL_01;
         2'b10:   s = CTL_10;
         default: s = CTL_11;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 registers the transition-minimised word q_m,
// stage 2 makes the DC-balance decision and registers the 10-bit symbol.
// Each channel keeps its own running disparity.
module tmds_channel
   import tmds_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n_i,
   input  logic       ce_i,
   input  logic [7:0] data_i,
   input  logic       de_i,
   input  logic [1:0] ctl_i,
   output tmds_sym_t  sym_o
);

   logic [8:0] qm_d;
   logic [8:0] qm_q;
   logic       de_s1_q;
   logic [1:0] ctl_s1_q;

   tmds_sym_t  sym_d;
   tmds_sym_t  sym_q;
   disp_t      cnt_d;
   disp_t      cnt_q;

   logic [3:0] n1d;
   logic       use_xnor;
   logic [3:0] n1;
   disp_t      diff;
   disp_t      two_q8;

   // Stage 1 combinational: pick XOR or XNOR chain to minimise transitions.
   always_comb begin
      logic [7:0] chain;
      n1d      = popcount8(data_i);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_i[0]);
      chain    = 8'h00;
      chain[0] = data_i[0];
      for (int i = 1; i < 8; i++) begin
         chain[i] = use_xnor ? ~(chain[i-1] ^ data_i[i]) : (chain[i-1] ^ data_i[i]);
      end
      qm_d = {~use_xnor, chain};
   end

   // Stage 2 combinational: DC-balance decision and disparity update.
   always_comb begin
      n1     = popcount8(qm_q[7:0]);
      // N1 - N0 = 2*N1 - 8; modulo-32 arithmetic keeps the result exact.
      diff   = $signed({n1, 1'b0}) - 5'sd8;
      two_q8 = qm_q[8] ? 5'sd2 : 5'sd0;
      sym_d  = sym_q;
      cnt_d  = cnt_q;
      if (!de_s1_q) begin
         // Blanking always restarts the disparity so each line begins balanced.
         sym_d = ctl_symbol(ctl_s1_q);
         cnt_d = 5'sd0;
      end else if ((cnt_q == 5'sd0) || (n1 == 4'd4)) begin
         sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((!cnt_q[4] && (n1 > 4'd4)) || (cnt_q[4] && (n1 < 4'd4))) begin
         sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_d = cnt_q + two_q8 - diff;
      end else begin
         sym_d = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_d = cnt_q - (5'sd2 - two_q8) + diff;
      end
   end

   // Pipeline and disparity registers; reset wins over the clock enable.
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         qm_q     <= 9'd0;
         de_s1_q  <= 1'b0;
         ctl_s1_q <= 2'b00;
         sym_q    <= CTL_00;
         cnt_q    <= 5'sd0;
      end else if (ce_i) begin
         qm_q     <= qm_d;
         de_s1_q  <= de_i;
         ctl_s1_q <= ctl_i;
         sym_q    <= sym_d;
         cnt_q    <= cnt_d;
      end
   end

   assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder.sv
// DVI-mode TMDS encoder: three channels plus sync routing and DE alignment.
// Optional macro TMDS_PIXEL_CE_EN adds a ce_pix port that qualifies every
// pipeline advance; without it the block advances on every clk_sys edge.
module tmds_encoder
   import tmds_pkg::*;
#(
   parameter int CTL_CH0_ONLY = 1
) (
   input  logic       clk_sys,
   input  logic       reset_n,
`ifdef TMDS_PIXEL_CE_EN
   input  logic       ce_pix,
`endif
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       de_in,
   output logic [9:0] tmds_ch0,
   output logic [9:0] tmds_ch1,
   output logic [9:0] tmds_ch2,
   output logic       de_out
);

   logic       ce;
   logic [7:0] ch_data [3];
   logic [1:0] ch_ctl  [3];
   tmds_sym_t  ch_sym  [3];
   logic       de_s1_q;
   logic       de_s2_q;

`ifdef TMDS_PIXEL_CE_EN
   assign ce = ce_pix;
`else
   assign ce = 1'b1;
`endif

   // Channel 0 = blue, 1 = green, 2 = red. Sync rides on blue only unless the
   // debug mode mirrors it onto green as well.
   assign ch_data[0] = b_in;
   assign ch_data[1] = g_in;
   assign ch_data[2] = r_in;
   assign ch_ctl[0]  = {vs_in, hs_in};
   assign ch_ctl[1]  = (CTL_CH0_ONLY != 0) ? 2'b00 : {vs_in, hs_in};
   assign ch_ctl[2]  = 2'b00;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ch
         tmds_channel u_ch (
            .clk     (clk_sys),
            .rst_n_i (reset_n),
            .ce_i    (ce),
            .data_i  (ch_data[gi]),
            .de_i    (de_in),
            .ctl_i   (ch_ctl[gi]),
            .sym_o   (ch_sym[gi])
         );
      end
   endgenerate

   // Two-stage DE delay so de_out lines up with the registered symbols.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         de_s1_q <= 1'b0;
         de_s2_q <= 1'b0;
      end else if (ce) begin
         de_s1_q <= de_in;
         de_s2_q <= de_s1_q;
      end
   end

   assign tmds_ch0 = ch_sym[0];
   assign tmds_ch1 = ch_sym[1];
   assign tmds_ch2 = ch_sym[2];
   assign de_out   = de_s2_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Testbench for tmds_encoder: directed scenarios plus a randomized run checked
// against a behavioural DVI encoder model with a pixel-level pipeline queue.
module tb_tmds_encoder;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       de;
      logic       hs;
      logic       vs;
   } pix_t;

   localparam logic [9:0] S_CTL00 = 10'b1101010100;
   localparam logic [9:0] S_CTL01 = 10'b0010101011;
   localparam logic [9:0] S_CTL10 = 10'b0101010100;
   localparam logic [9:0] S_CTL11 = 10'b1010101011;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce_pix  = 1'b1;
   logic [7:0] r_in = 8'h00, g_in = 8'h00, b_in = 8'h00;
   logic       hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
   logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
   logic       de_out;

   int total = 0;
   int bad   = 0;

   // Reference model state
   pix_t       pipe[$];
   pix_t       exp_pix;
   int         mcnt [3];
   logic [9:0] exp_ch0, exp_ch1, exp_ch2;
   logic       exp_de;

   tmds_encoder dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
`ifdef TMDS_PIXEL_CE_EN
      .ce_pix   (ce_pix),
`endif
      .r_in     (r_in),
      .g_in     (g_in),
      .b_in     (b_in),
      .hs_in    (hs_in),
      .vs_in    (vs_in),
      .de_in    (de_in),
      .tmds_ch0 (tmds_ch0),
      .tmds_ch1 (tmds_ch1),
      .tmds_ch2 (tmds_ch2),
      .de_out   (de_out)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] ctl_sym(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return S_CTL00;
         2'b01:   return S_CTL01;
         2'b10:   return S_CTL10;
         default: return S_CTL11;
      endcase
   endfunction

   // DVI 1.0 encoding of one byte with integer disparity for channel ch.
   function automatic logic [9:0] enc(input logic [7:0] d, input int ch);
      int         n1d, n1, n0;
      bit         use_xnor;
      logic [8:0] qm;
      logic [9:0] o;
      n1d      = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = use_xnor ? 1'b0 : 1'b1;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (mcnt[ch] == 0 || n1 == n0) begin
         o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
         o = {1'b1, qm[8], ~qm[7:0]};
         mcnt[ch] += 2 * int'(qm[8]) + (n0 - n1);
      end else begin
         o = {1'b0, qm[8], qm[7:0]};
         mcnt[ch] += -2 * int'(!qm[8]) + (n1 - n0);
      end
      return o;
   endfunction

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++)
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   task automatic set_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic de, input logic hs, input logic vs);
      r_in = r; g_in = g; b_in = b; de_in = de; hs_in = hs; vs_in = vs;
   endtask

   // Advance one clock and update the model; outputs are sampled 1 unit later.
   task automatic tick();
      pix_t cur;
      @(posedge clk_sys);
      #1;
      cur = '{r: r_in, g: g_in, b: b_in, de: de_in, hs: hs_in, vs: vs_in};
      if (!reset_n) begin
         pipe.delete();
         pipe.push_back('0);
         mcnt    = '{0, 0, 0};
         exp_ch0 = S_CTL00; exp_ch1 = S_CTL00; exp_ch2 = S_CTL00;
         exp_de  = 1'b0;
         exp_pix = '0;
      end else if (ce_pix) begin
         pipe.push_back(cur);
         exp_pix = pipe.pop_front();
         exp_de  = exp_pix.de;
         if (exp_pix.de) begin
            exp_ch0 = enc(exp_pix.b, 0);
            exp_ch1 = enc(exp_pix.g, 1);
            exp_ch2 = enc(exp_pix.r, 2);
         end else begin
            exp_ch0 = ctl_sym(exp_pix.vs, exp_pix.hs);
            exp_ch1 = S_CTL00;
            exp_ch2 = S_CTL00;
            mcnt    = '{0, 0, 0};
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_px(8'hAB, 8'hAB, 8'hAB, 1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      total += 4;
      if (tmds_ch0 !== 10'h354) begin bad++; $display("FAIL reset_ch0 got=%h want=354", tmds_ch0); end
      if (tmds_ch1 !== 10'h354) begin bad++; $display("FAIL reset_ch1 got=%h want=354", tmds_ch1); end
      if (tmds_ch2 !== 10'h354) begin bad++; $display("FAIL reset_ch2 got=%h want=354", tmds_ch2); end
      if (de_out !== 1'b0)      begin bad++; $display("FAIL reset_de got=%b want=0", de_out); end
      reset_n = 1'b1;
      tick();
      total += 2;
      if (tmds_ch0 !== 10'h354) begin bad++; $display("FAIL rel1_ch0 got=%h want=354", tmds_ch0); end
      if (de_out !== 1'b0)      begin bad++; $display("FAIL rel1_de got=%b want=0", de_out); end
      tick();
      total += 4;
      if (tmds_ch0 !== 10'h2CC) begin bad++; $display("FAIL rel2_ch0 got=%h want=2cc", tmds_ch0); end
      if (tmds_ch1 !== 10'h2CC) begin bad++; $display("FAIL rel2_ch1 got=%h want=2cc", tmds_ch1); end
      if (tmds_ch2 !== 10'h2CC) begin bad++; $display("FAIL rel2_ch2 got=%h want=2cc", tmds_ch2); end
      if (de_out !== 1'b1)      begin bad++; $display("FAIL rel2_de got=%b want=1", de_out); end
      $display("reset: first symbol ch0=%h de_out=%b", tmds_ch0, de_out);
   endtask

   task automatic test_blanking();
      logic [1:0]  sv [3];
      logic [9:0]  want [3];
      sv   = '{2'b01, 2'b10, 2'b11};   // {vs,hs}
      want = '{S_CTL01, S_CTL10, S_CTL11};
      for (int k = 0; k < 3; k++) begin
         set_px(8'h5A, 8'hC3, 8'h0F, 1'b0, sv[k][0], sv[k][1]);
         tick(); tick();
         total += 4;
         if (tmds_ch0 !== want[k]) begin bad++; $display("FAIL blank_ch0 vs,hs=%b got=%h want=%h", sv[k], tmds_ch0, want[k]); end
         if (tmds_ch1 !== S_CTL00) begin bad++; $display("FAIL blank_ch1 vs,hs=%b got=%h want=354", sv[k], tmds_ch1); end
         if (tmds_ch2 !== S_CTL00) begin bad++; $display("FAIL blank_ch2 vs,hs=%b got=%h want=354", sv[k], tmds_ch2); end
         if (de_out !== 1'b0)      begin bad++; $display("FAIL blank_de vs,hs=%b got=%b want=0", sv[k], de_out); end
         $display("blank vs,hs=%b ch0=%h ch1=%h ch2=%h", sv[k], tmds_ch0, tmds_ch1, tmds_ch2);
      end
   endtask

   task automatic test_disparity();
      logic [9:0] want [4];
      int         wdisp [4];
      int         rd;
      want  = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
      wdisp = '{-8, 2, -6, 4};
      rd    = 0;
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      set_px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
         tick();
         rd += 2 * $countones(tmds_ch0) - 10;
         total += 3;
         if (tmds_ch0 !== want[i]) begin bad++; $display("FAIL disp_sym px%0d got=%h want=%h", i, tmds_ch0, want[i]); end
         if (rd != wdisp[i])       begin bad++; $display("FAIL disp_cnt px%0d got=%0d want=%0d", i, rd, wdisp[i]); end
         if (de_out !== 1'b1)      begin bad++; $display("FAIL disp_de px%0d got=%b want=1", i, de_out); end
         $display("disparity px%0d ch0=%h running=%0d", i, tmds_ch0, rd);
      end
      tick();
   endtask

   task automatic test_midline_blank();
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      for (int i = 0; i < 6; i++) begin
         set_px((i % 2) ? 8'hFF : 8'h00, (i % 2) ? 8'h00 : 8'hFF, 8'h3C + 8'(i), 1'b1, 1'b0, 1'b0);
         tick();
         total += 3;
         if (tmds_ch0 !== exp_ch0) begin bad++; $display("FAIL mid_ch0 i=%0d got=%h want=%h", i, tmds_ch0, exp_ch0); end
         if (tmds_ch1 !== exp_ch1) begin bad++; $display("FAIL mid_ch1 i=%0d got=%h want=%h", i, tmds_ch1, exp_ch1); end
         if (tmds_ch2 !== exp_ch2) begin bad++; $display("FAIL mid_ch2 i=%0d got=%h want=%h", i, tmds_ch2, exp_ch2); end
      end
      // One blank pixel; the last data pixel is still emerging.
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (de_out !== 1'b1) begin bad++; $display("FAIL mid_pre_de got=%b want=1", de_out); end
      set_px(8'hAB, 8'hAB, 8'hAB, 1'b1, 1'b0, 1'b0);
      tick();
      total += 2;
      if (tmds_ch0 !== 10'h354) begin bad++; $display("FAIL mid_ctl_ch0 got=%h want=354", tmds_ch0); end
      if (de_out !== 1'b0)      begin bad++; $display("FAIL mid_ctl_de got=%b want=0", de_out); end
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      total += 4;
      if (tmds_ch0 !== 10'h2CC) begin bad++; $display("FAIL mid_post_ch0 got=%h want=2cc", tmds_ch0); end
      if (tmds_ch1 !== 10'h2CC) begin bad++; $display("FAIL mid_post_ch1 got=%h want=2cc", tmds_ch1); end
      if (tmds_ch2 !== 10'h2CC) begin bad++; $display("FAIL mid_post_ch2 got=%h want=2cc", tmds_ch2); end
      if (de_out !== 1'b1)      begin bad++; $display("FAIL mid_post_de got=%b want=1", de_out); end
      $display("midline: after one-cycle blank ch0=%h de_out=%b", tmds_ch0, de_out);
      tick();
   endtask

   task automatic test_random();
      int npix, run, de_len, bl_len;
      int rd [3];
      logic [9:0] sym;
      logic [7:0] byt;
      npix = 0; run = 0;
      rd   = '{0, 0, 0};
      while (npix < 10000) begin
         de_len = $urandom_range(1, 40);
         bl_len = $urandom_range(1, 12);
         for (int p = 0; p < de_len + bl_len; p++) begin
            set_px(8'($urandom), 8'($urandom), 8'($urandom), (p < de_len),
                   1'($urandom), 1'($urandom));
            tick();
            npix++;
            total += 4;
            if (tmds_ch0 !== exp_ch0) begin bad++; $display("FAIL rnd_ch0 px=%0d got=%h want=%h", npix, tmds_ch0, exp_ch0); end
            if (tmds_ch1 !== exp_ch1) begin bad++; $display("FAIL rnd_ch1 px=%0d got=%h want=%h", npix, tmds_ch1, exp_ch1); end
            if (tmds_ch2 !== exp_ch2) begin bad++; $display("FAIL rnd_ch2 px=%0d got=%h want=%h", npix, tmds_ch2, exp_ch2); end
            if (de_out !== exp_de)    begin bad++; $display("FAIL rnd_de px=%0d got=%b want=%b", npix, de_out, exp_de); end
            for (int c = 0; c < 3; c++) begin
               sym = (c == 0) ? tmds_ch0 : (c == 1) ? tmds_ch1 : tmds_ch2;
               byt = (c == 0) ? exp_pix.b : (c == 1) ? exp_pix.g : exp_pix.r;
               if (exp_de) begin
                  rd[c] += 2 * $countones(sym) - 10;
                  total += 2;
                  if (dec(sym) !== byt) begin bad++; $display("FAIL rnd_decode ch%0d px=%0d got=%h want=%h", c, npix, dec(sym), byt); end
                  if (rd[c] > 10 || rd[c] < -10) begin bad++; $display("FAIL rnd_bound ch%0d px=%0d got=%0d want=|x|<=10", c, npix, rd[c]); end
               end else begin
                  rd[c] = 0;
               end
            end
         end
         run++;
         $display("random run %0d: de_len=%0d blank_len=%0d pixels=%0d", run, de_len, bl_len, npix);
      end
   endtask

`ifdef TMDS_PIXEL_CE_EN
   task automatic test_ce();
      logic [9:0] want [4];
      int         k;
      logic [9:0] w;
      want = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
      ce_pix = 1'b1;
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      set_px(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      k = 0;
      for (int c = 0; c < 20; c++) begin
         ce_pix = (c % 4 == 3);
         tick();
         if (ce_pix) k++;
         w = (k <= 1) ? S_CTL00 : want[k-2];
         total += 2;
         if (tmds_ch0 !== w)       begin bad++; $display("FAIL ce_sym c=%0d got=%h want=%h", c, tmds_ch0, w); end
         if (tmds_ch0 !== exp_ch0) begin bad++; $display("FAIL ce_model c=%0d got=%h want=%h", c, tmds_ch0, exp_ch0); end
         $display("ce cycle %0d ce=%b ch0=%h", c, ce_pix, tmds_ch0);
      end
      ce_pix = 1'b1;
      set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_blanking();
      test_disparity();
      test_midline_blank();
`ifdef TMDS_PIXEL_CE_EN
      test_ce();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
